pwm_gen_multi: RTL and testbench

Parametrised multi-channel PWM generator that shares one internal period counter across `CHANNELS` outputs. Each channel has its own mode, polarity and compare pair. All configuration is double-buffered: writes land in shadow registers and commit to the active set only at a period boundary, so the outputs never glitch mid-period. It sits behind the peripheral register block and drives the top-level PWM pins, replacing the single-channel generator that relied on an external counter.

---
 rtl/pwm_gen_multi.sv | 143 ++++++++++++++
 tb/tb_pwm_gen_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator sharing one period counter across all outputs.
// Configuration is double-buffered: shadows commit at a period wrap, or continuously while disabled.
module pwm_gen_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned WIDTH    = 16,
  localparam int unsigned SelW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                period_we,
  input  logic [WIDTH-1:0]    period_in,
  input  logic                cfg_we,
  input  logic [SelW-1:0]     cfg_sel,
  input  logic [1:0]          cfg_mode,
  input  logic                cfg_pol,
  input  logic [WIDTH-1:0]    cfg_cmp1,
  input  logic [WIDTH-1:0]    cfg_cmp2,
  output logic [CHANNELS-1:0] pwm_out,
  output logic [WIDTH-1:0]    count_val,
  output logic                period_wrap,
  output logic                update_done
);

  localparam logic [1:0] ModeLeft  = 2'b00;
  localparam logic [1:0] ModeRight = 2'b01;
  localparam logic [1:0] ModeRange = 2'b10;

  logic [1:0]       sh_mode_q [CHANNELS];
  logic [1:0]       sh_mode_d [CHANNELS];
  logic [1:0]       act_mode_q [CHANNELS];
  logic [1:0]       act_mode_d [CHANNELS];
  logic [WIDTH-1:0] sh_cmp1_q [CHANNELS];
  logic [WIDTH-1:0] sh_cmp1_d [CHANNELS];
  logic [WIDTH-1:0] act_cmp1_q [CHANNELS];
  logic [WIDTH-1:0] act_cmp1_d [CHANNELS];
  logic [WIDTH-1:0] sh_cmp2_q [CHANNELS];
  logic [WIDTH-1:0] sh_cmp2_d [CHANNELS];
  logic [WIDTH-1:0] act_cmp2_q [CHANNELS];
  logic [WIDTH-1:0] act_cmp2_d [CHANNELS];
  logic [CHANNELS-1:0] sh_pol_q, sh_pol_d, act_pol_q, act_pol_d;
  logic [WIDTH-1:0] sh_period_q, sh_period_d, act_period_q, act_period_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, last;
  logic [CHANNELS-1:0] pwm_q, pwm_d, raw;
  logic pending_q, pending_d, done_q, done_d;
  logic wrap, commit, cfg_hit, any_write;

  // Periods 0 and 1 both collapse to a single-count period.
  assign last      = (act_period_q == '0) ? '0 : act_period_q - WIDTH'(1);
  assign wrap      = en && (cnt_q >= last);
  assign commit    = (pending_q && wrap) || !en;
  assign cfg_hit   = cfg_we && (32'(cfg_sel) < CHANNELS);
  assign any_write = period_we || cfg_hit;

  always_comb begin
    sh_mode_d    = sh_mode_q;
    sh_cmp1_d    = sh_cmp1_q;
    sh_cmp2_d    = sh_cmp2_q;
    sh_pol_d     = sh_pol_q;
    sh_period_d  = sh_period_q;
    act_mode_d   = act_mode_q;
    act_cmp1_d   = act_cmp1_q;
    act_cmp2_d   = act_cmp2_q;
    act_pol_d    = act_pol_q;
    act_period_d = act_period_q;
    cnt_d        = en ? (wrap ? '0 : cnt_q + WIDTH'(1)) : '0;
    // Commit copies the pre-write shadows; a same-cycle write stays pending.
    if (commit) begin
      act_mode_d   = sh_mode_q;
      act_cmp1_d   = sh_cmp1_q;
      act_cmp2_d   = sh_cmp2_q;
      act_pol_d    = sh_pol_q;
      act_period_d = sh_period_q;
    end
    if (period_we) sh_period_d = period_in;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (cfg_hit && (32'(cfg_sel) == k)) begin
        sh_mode_d[k] = cfg_mode;
        sh_pol_d[k]  = cfg_pol;
        sh_cmp1_d[k] = cfg_cmp1;
        sh_cmp2_d[k] = cfg_cmp2;
      end
    end
    pending_d = any_write || (pending_q && !commit);
    done_d    = commit && pending_q;
  end

  always_comb begin
    raw   = '0;
    pwm_d = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      case (act_mode_q[k])
        ModeLeft:  raw[k] = cnt_q < act_cmp1_q[k];
        ModeRight: raw[k] = cnt_q >= act_cmp1_q[k];
        ModeRange: raw[k] = (cnt_q >= act_cmp1_q[k]) && (cnt_q < act_cmp2_q[k]);
        default:   raw[k] = 1'b0;
      endcase
      pwm_d[k] = (en && raw[k]) ^ act_pol_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        sh_mode_q[k]  <= '0;
        sh_cmp1_q[k]  <= '0;
        sh_cmp2_q[k]  <= '0;
        act_mode_q[k] <= '0;
        act_cmp1_q[k] <= '0;
        act_cmp2_q[k] <= '0;
      end
      sh_pol_q     <= '0;
      act_pol_q    <= '0;
      sh_period_q  <= '0;
      act_period_q <= '0;
      cnt_q        <= '0;
      pwm_q        <= '0;
      pending_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      sh_mode_q    <= sh_mode_d;
      sh_cmp1_q    <= sh_cmp1_d;
      sh_cmp2_q    <= sh_cmp2_d;
      act_mode_q   <= act_mode_d;
      act_cmp1_q   <= act_cmp1_d;
      act_cmp2_q   <= act_cmp2_d;
      sh_pol_q     <= sh_pol_d;
      act_pol_q    <= act_pol_d;
      sh_period_q  <= sh_period_d;
      act_period_q <= act_period_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
    end
  end

  assign pwm_out     = pwm_q;
  assign count_val   = cnt_q;
  assign period_wrap = wrap && !rst;
  assign update_done = done_q;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: directed scenarios plus random traffic, checked cycle by cycle
// against a behavioural model of the channel rules.
module tb_pwm_gen_multi;
  localparam int CH = 4;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          rst, en, period_we, cfg_we, cfg_pol;
  logic [W-1:0]  period_in, cfg_cmp1, cfg_cmp2;
  logic [1:0]    cfg_sel, cfg_mode;
  logic [CH-1:0] pwm_out;
  logic [W-1:0]  count_val;
  logic          period_wrap, update_done;

  int vectors = 0;
  int errors  = 0;

  // Behavioural model state
  int s_mode[CH], s_pol[CH], s_c1[CH], s_c2[CH], s_per;
  int a_mode[CH], a_pol[CH], a_c1[CH], a_c2[CH], a_per;
  int m_cnt;
  logic [CH-1:0] m_pwm;
  bit m_done, m_pend;

  always #5 clk = ~clk;

  pwm_gen_multi #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en),
    .period_we(period_we), .period_in(period_in),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode), .cfg_pol(cfg_pol),
    .cfg_cmp1(cfg_cmp1), .cfg_cmp2(cfg_cmp2),
    .pwm_out(pwm_out), .count_val(count_val),
    .period_wrap(period_wrap), .update_done(update_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int last_of(input int per);
    return (per <= 1) ? 0 : per - 1;
  endfunction

  function automatic bit level(input int mode, input int c1, input int c2, input int cnt);
    if (mode == 0) return cnt < c1;
    if (mode == 1) return cnt >= c1;
    if (mode == 2) return (c1 <= cnt) && (cnt < c2);
    return 1'b0;
  endfunction

  task automatic model_step();
    bit wrap, commit, wrote;
    if (rst) begin
      for (int k = 0; k < CH; k++) begin
        s_mode[k] = 0; s_pol[k] = 0; s_c1[k] = 0; s_c2[k] = 0;
        a_mode[k] = 0; a_pol[k] = 0; a_c1[k] = 0; a_c2[k] = 0;
      end
      s_per = 0; a_per = 0; m_cnt = 0; m_pwm = '0; m_done = 0; m_pend = 0;
      return;
    end
    wrap = en && (m_cnt >= last_of(a_per));
    for (int k = 0; k < CH; k++)
      m_pwm[k] = (en ? level(a_mode[k], a_c1[k], a_c2[k], m_cnt) : 1'b0) ^ a_pol[k][0];
    commit = (m_pend && wrap) || !en;
    m_done = commit && m_pend;
    m_cnt  = !en ? 0 : (wrap ? 0 : (m_cnt + 1) % 65536);
    if (commit) begin
      a_mode = s_mode; a_pol = s_pol; a_c1 = s_c1; a_c2 = s_c2; a_per = s_per;
    end
    wrote = 0;
    if (period_we) begin s_per = int'(period_in); wrote = 1; end
    if (cfg_we && int'(cfg_sel) < CH) begin
      s_mode[cfg_sel] = int'(cfg_mode); s_pol[cfg_sel] = int'(cfg_pol);
      s_c1[cfg_sel] = int'(cfg_cmp1); s_c2[cfg_sel] = int'(cfg_cmp2);
      wrote = 1;
    end
    if (wrote) m_pend = 1;
    else if (commit) m_pend = 0;
  endtask

  // Inputs are set at the falling edge; one call spans one rising edge.
  task automatic cycle();
    bit mw;
    #1;
    mw = !rst && en && (m_cnt >= last_of(a_per));
    chk("period_wrap", period_wrap, mw);
    @(posedge clk);
    model_step();
    #1;
    chk("count_val", count_val, m_cnt);
    chk("pwm_out", pwm_out, m_pwm);
    chk("update_done", update_done, m_done);
    @(negedge clk);
  endtask

  task automatic set_cfg(input int sel, input int mode, input int pol, input int c1, input int c2);
    cfg_we = 1; cfg_sel = sel[1:0]; cfg_mode = mode[1:0]; cfg_pol = pol[0];
    cfg_cmp1 = c1[W-1:0]; cfg_cmp2 = c2[W-1:0];
    cycle();
    cfg_we = 0;
  endtask

  task automatic set_period(input int per);
    period_we = 1; period_in = per[W-1:0];
    cycle();
    period_we = 0;
  endtask

  task automatic run_until(input int target);
    int n = 0;
    while (int'(count_val) != target && n < 40) begin cycle(); n++; end
    chk("wait_count", count_val, target);
  endtask

  // Counts high cycles of one channel over the next ten cycles.
  task automatic duty10(input string tag, input int ch, input int exp);
    int hi = 0;
    for (int i = 0; i < 10; i++) begin cycle(); hi += int'(pwm_out[ch]); end
    chk(tag, hi, exp);
  endtask

  initial begin
    rst = 1; en = 1; period_we = 0; cfg_we = 1; cfg_pol = 0;
    period_in = '0; cfg_cmp1 = 16'd5; cfg_cmp2 = '0; cfg_sel = '0; cfg_mode = '0;
    @(negedge clk);
    cycle(); cycle();
    chk("rst_pwm", pwm_out, 0);
    chk("rst_cnt", count_val, 0);
    chk("rst_wrap", period_wrap, 0);
    chk("rst_done", update_done, 0);
    rst = 0; en = 0; cfg_we = 0;
    repeat (3) cycle();
    chk("idle_pwm", pwm_out, 0);

    // Left mode on ch0, period 10, cmp1 3
    set_period(10);
    set_cfg(0, 0, 0, 3, 0);
    cycle();
    en = 1;
    cycle();
    duty10("left_duty3", 0, 3);

    // Range mode on ch2 with inverted polarity
    set_cfg(2, 2, 1, 2, 6);
    run_until(9); cycle();
    duty10("range_duty", 2, 6);
    set_cfg(2, 2, 1, 2, 2);
    run_until(9); cycle();
    duty10("range_empty", 2, 10);

    // Shadow update mid-period on ch0
    run_until(4);
    set_cfg(0, 0, 0, 7, 0);
    run_until(9); cycle();
    chk("upd_pulse", update_done, 1);
    duty10("left_duty7", 0, 7);
    // Write landing in the count-9 cycle
    run_until(9);
    set_cfg(0, 0, 0, 3, 0);
    duty10("late_keep7", 0, 7);
    duty10("late_duty3", 0, 3);

    // Period 1 and 0 on ch1
    set_cfg(1, 0, 0, 1, 0);
    set_period(1);
    run_until(0);
    repeat (12) cycle();
    chk("p1_pwm1", pwm_out[1], 1);
    chk("p1_cnt", count_val, 0);
    set_period(0);
    repeat (3) cycle();
    chk("p0_pwm1", pwm_out[1], 1);
    set_cfg(1, 0, 0, 0, 0);
    repeat (3) cycle();
    chk("p0_cmp0", pwm_out[1], 0);

    // Enable drop at count 5, then reset with an update pending
    set_period(10);
    repeat (3) cycle();
    run_until(5);
    en = 0; cycle();
    chk("drop_cnt", count_val, 0);
    en = 1; repeat (4) cycle();
    run_until(3);
    set_cfg(3, 1, 1, 4, 0);
    run_until(6);
    rst = 1; cycle();
    rst = 0;
    repeat (25) cycle();
    chk("rst_discard", pwm_out, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      en        = ($urandom_range(0, 19) != 0);
      period_we = ($urandom_range(0, 15) == 0);
      period_in = W'($urandom_range(0, 12));
      cfg_we    = ($urandom_range(0, 5) == 0);
      cfg_sel   = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_pol   = 1'($urandom_range(0, 1));
      cfg_cmp1  = W'($urandom_range(0, 14));
      cfg_cmp2  = W'($urandom_range(0, 14));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
